// File: rtl/ram_pattern_tester_pkg.sv
// Shared types and helpers for the RAM pattern tester.
// Holds the test state encoding, LED bit positions and the address-derived pattern.
// No logic of its own; imported by the tester and its interface users.
package ram_pattern_tester_pkg;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_READ  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'hA5C3_0F96;
    localparam logic [31:0] ADDR_SPREAD  = 32'h0101_0101;

    localparam int LED_PASS = 7;
    localparam int LED_FAIL = 6;
    localparam int LED_BUSY = 5;  // doubles as the timeout flag in FAIL

    // Word pattern: seed XOR address spread across all four bytes, inverted on odd passes
    // so consecutive passes flip every bit of every cell.
    function automatic logic [31:0] pattern(input logic [31:0] addr,
                                            input logic [7:0]  pass,
                                            input logic [31:0] seed = DEFAULT_SEED);
        logic [31:0] p;
        p = seed ^ (addr * ADDR_SPREAD);
        if (pass[0]) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_pattern_tester_if.sv
// Wishbone bus between the pattern tester (master) and the RAM slave.
// Purely a bundle of wires; no latency of its own.
// Flow control is the Wishbone CYC/STB and ACK pair.
interface ram_pattern_tester_if;
    logic        pinWbCycleStrobe;
    logic        pinWbWriteEnable;
    logic [31:0] pinWbAddress;
    logic [31:0] pinWbWriteData;
    logic [31:0] pinWbReadData;
    logic        pinWbAck;

    modport master (
        output pinWbCycleStrobe,
        output pinWbWriteEnable,
        output pinWbAddress,
        output pinWbWriteData,
        input  pinWbReadData,
        input  pinWbAck
    );

    modport slave (
        input  pinWbCycleStrobe,
        input  pinWbWriteEnable,
        input  pinWbAddress,
        input  pinWbWriteData,
        output pinWbReadData,
        output pinWbAck
    );
endinterface

// File: rtl/ram_pattern_tester_wb_ack_watchdog.sv
// Ack watchdog: counts enabled cycles since the last clear and flags expiry.
// Expiry is combinational from the count, asserted in the TIMEOUT_CYCLES-th enabled cycle.
// No handshake; the owner decides whether an ack in the same cycle overrides expiry.
module wb_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/ram_pattern_tester.sv
// Wishbone test master: writes pattern(addr,pass) to every word, reads back and compares.
// One transfer per ack, next transfer presented the cycle after; all pins registered.
// Holds strobe until ack; a silent slave is caught by the watchdog (RAMTEST_CONTINUOUS_EN loops passes).
module ram_pattern_tester
    import ram_pattern_tester_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] SEED           = DEFAULT_SEED,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                 pinClock,
    input  logic                 pinReset,
    ram_pattern_tester_if.master wb,
    output logic [7:0]           pinLeds
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              pass_q, pass_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic                    timeout_q, timeout_d;
    logic [31:0]             wdat_q, wdat_d;
    logic [7:0]              leds_q, leds_d;
    logic [31:0]             addr_ext_d;

    logic xfer;
    logic wd_clr;
    logic wd_expired;

    // A transfer only counts while we are actually strobing.
    assign xfer   = stb_q && wb.pinWbAck;
    assign wd_clr = xfer || (state_d != state_q);

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (pinClock),
        .rst       (pinReset),
        .clr_i     (wd_clr),
        .en_i      (stb_q),
        .expired_o (wd_expired)
    );

    // Next-state, next-address and next registered pin values.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pass_d    = pass_q;
        stb_d     = stb_q;
        we_d      = we_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_WRITE: begin
                if (!stb_q) begin
                    // First cycle out of reset: open the bus on word 0.
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                end else if (xfer) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        we_d    = 1'b0;
                        state_d = ST_READ;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d   = ST_FAIL;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_READ: begin
                if (xfer) begin
                    if (wb.pinWbReadData != pattern(32'(addr_q), pass_q, SEED)) begin
                        state_d = ST_FAIL;
                        stb_d   = 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
`ifdef RAMTEST_CONTINUOUS_EN
                        pass_d  = pass_q + 8'd1;
                        addr_d  = '0;
                        we_d    = 1'b1;
                        state_d = ST_WRITE;
`else
                        state_d = ST_DONE;
                        stb_d   = 1'b0;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d   = ST_FAIL;
                    stb_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                // DONE and FAIL park the bus until reset.
                stb_d = 1'b0;
                we_d  = 1'b0;
            end
        endcase

        addr_ext_d = 32'(addr_d);
        wdat_d     = we_d ? pattern(addr_ext_d, pass_d, SEED) : 32'd0;

        leds_d = 8'd0;
        case (state_d)
            ST_DONE: leds_d[LED_PASS] = 1'b1;
            ST_FAIL: begin
                leds_d[LED_FAIL] = 1'b1;
                leds_d[LED_BUSY] = timeout_d;
                leds_d[4:0]      = addr_ext_d[4:0];
            end
            default: begin
                leds_d[LED_BUSY] = 1'b1;
                leds_d[4:0]      = pass_d[4:0];
            end
        endcase
    end

    // State and registered bus/LED outputs; reset drops every pin immediately.
    always_ff @(posedge pinClock or posedge pinReset) begin
        if (pinReset) begin
            state_q   <= ST_WRITE;
            addr_q    <= '0;
            pass_q    <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
            wdat_q    <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            timeout_q <= timeout_d;
            wdat_q    <= wdat_d;
            leds_q    <= leds_d;
        end
    end

    assign wb.pinWbCycleStrobe = stb_q;
    assign wb.pinWbWriteEnable = we_q;
    assign wb.pinWbAddress     = 32'(addr_q);
    assign wb.pinWbWriteData   = wdat_q;
    assign pinLeds             = leds_q;

endmodule
